// File: rtl/unidad_control_multiciclo.sv
// unidad_control_multiciclo: multi-cycle MIPS control unit.
// A Moore FSM walks each instruction through fetch, decode, execute,
// memory and writeback, with a bounded memory-ready handshake.
// Optional build macro ILLEGAL_OP_TRAP_EN: an unknown opcode parks the FSM
// in TRAP and raises IllegalOp; without it, unknown opcodes retire as a NOP.
module unidad_control_multiciclo #(
    parameter int unsigned OP_W     = 6,
    parameter int unsigned ALUOP_W  = 3,
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               Enable,
    input  logic [OP_W-1:0]    OpCode,
    input  logic               Zero,
    input  logic               MemReady,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemToReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [1:0]         PCSrc,
    output logic               InstrDone,
    output logic               MemTimeout,
    output logic [3:0]         State
`ifdef ILLEGAL_OP_TRAP_EN
    ,
    output logic               IllegalOp
`endif
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        MEMADR = 4'd3,
        MEMRD  = 4'd4,
        MEMWB  = 4'd5,
        MEMWR  = 4'd6,
        EXEC   = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9,
        ADDIEX = 4'd10,
        ADDIWB = 4'd11,
        JUMP   = 4'd12,
        TRAP   = 4'd13
    } state_t;

    localparam logic [OP_W-1:0]    OP_RTYPE = OP_W'(6'b000000);
    localparam logic [OP_W-1:0]    OP_LW    = OP_W'(6'b100011);
    localparam logic [OP_W-1:0]    OP_SW    = OP_W'(6'b101011);
    localparam logic [OP_W-1:0]    OP_BEQ   = OP_W'(6'b000100);
    localparam logic [OP_W-1:0]    OP_ADDI  = OP_W'(6'b001000);
    localparam logic [OP_W-1:0]    OP_J     = OP_W'(6'b000010);

    localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(3'b000);
    localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(3'b001);
    localparam logic [ALUOP_W-1:0] ALU_RTYP = ALUOP_W'(3'b010);

    state_t     state;
    state_t     nextState;
    logic [7:0] waitCnt;
    logic       inWait;
    logic       waitExpired;
    logic       retiring;
    logic       unusedZero;

    // Zero is consumed by the datapath's PCWriteCond gating, not by the FSM.
    assign unusedZero = Zero;

    // A stall times out on the cycle the counter would step onto WAIT_MAX;
    // MemReady in that same cycle still completes the access.
    assign inWait      = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
    assign waitExpired = inWait && !MemReady && (waitCnt == 8'(WAIT_MAX - 1));

    // Next-state selection; retiring states fold back to FETCH or IDLE on Enable.
    always_comb begin
        nextState = state;
        retiring  = 1'b0;
        if (waitExpired) begin
            nextState = IDLE;
        end else begin
            unique case (state)
                IDLE:   if (Enable) nextState = FETCH;
                FETCH:  if (MemReady) nextState = DECODE;
                DECODE: begin
                    if (OpCode == OP_RTYPE)                       nextState = EXEC;
                    else if ((OpCode == OP_LW) || (OpCode == OP_SW)) nextState = MEMADR;
                    else if (OpCode == OP_BEQ)                    nextState = BRANCH;
                    else if (OpCode == OP_ADDI)                   nextState = ADDIEX;
                    else if (OpCode == OP_J)                      nextState = JUMP;
                    else begin
`ifdef ILLEGAL_OP_TRAP_EN
                        nextState = TRAP;
`else
                        retiring = 1'b1;
`endif
                    end
                end
                MEMADR: nextState = (OpCode == OP_SW) ? MEMWR : MEMRD;
                MEMRD:  if (MemReady) nextState = MEMWB;
                MEMWR:  if (MemReady) retiring = 1'b1;
                EXEC:   nextState = ALUWB;
                ADDIEX: nextState = ADDIWB;
                MEMWB, ALUWB, BRANCH, ADDIWB, JUMP: retiring = 1'b1;
                TRAP:   nextState = TRAP;
                default: nextState = IDLE;
            endcase
            if (retiring) nextState = Enable ? FETCH : IDLE;
        end
    end

    // State, wait counter, retire pulse and sticky timeout flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            waitCnt    <= '0;
            InstrDone  <= 1'b0;
            MemTimeout <= 1'b0;
        end else begin
            state     <= nextState;
            InstrDone <= retiring;
            if (waitExpired) MemTimeout <= 1'b1;
            if (inWait && !MemReady && !waitExpired) waitCnt <= waitCnt + 8'd1;
            else                                     waitCnt <= '0;
        end
    end

    // Moore decode of the datapath controls; only the FETCH loads see MemReady.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemToReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = ALU_ADD;
        PCSrc       = 2'b00;
`ifdef ILLEGAL_OP_TRAP_EN
        IllegalOp   = (state == TRAP);
`endif
        unique case (state)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = MemReady;
                PCWrite = MemReady;
            end
            DECODE: ALUSrcB = 2'b11;
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            MEMWB: begin
                RegWrite = 1'b1;
                MemToReg = 1'b1;
            end
            MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALU_RTYP;
            end
            ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALU_SUB;
                PCWriteCond = 1'b1;
                PCSrc       = 2'b01;
            end
            ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            ADDIWB: RegWrite = 1'b1;
            JUMP: begin
                PCWrite = 1'b1;
                PCSrc   = 2'b10;
            end
            default: ;
        endcase
    end

    assign State = state;

endmodule
